// File: rtl/frac_cen_gen.sv
// frac_cen_gen: multi-channel fractional clock-enable generator (phase accumulators).
// Latency: enables are registered; a pulse is visible the cycle after the carrying edge.
// Backpressure: single pending increment slot; o_inc_rdy is low until the slot is applied.
//
// Ports:
//   i_clk, i_rst         master clock, synchronous active-high reset
//   i_run                global run; low freezes accumulators and o_clk, zeroes enables
//   i_inc_wr/ch/val      increment write (accepted with o_inc_rdy high)
//   o_inc_rdy            pending slot empty
//   o_cen, o_cenb        per-channel enable and its half-period-shifted twin
//   o_clk                per-channel registered square clock built from the enable pair
module frac_cen_gen #(
  parameter int                    NCH    = 4,
  parameter int                    ACC_W  = 16,
  parameter logic [NCH*ACC_W-1:0]  INC    = {NCH{ACC_W'(4891)}},
  parameter logic [NCH*ACC_W-1:0]  PHASE0 = '0,
  localparam int                   CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_inc_wr,
  input  logic [CH_W-1:0]  i_inc_ch,
  input  logic [ACC_W-1:0] i_inc_val,
  output logic             o_inc_rdy,
  output logic [NCH-1:0]   o_cen,
  output logic [NCH-1:0]   o_cenb,
  output logic [NCH-1:0]   o_clk
);

  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (ACC_W - 1);

  logic [ACC_W-1:0] acc_q   [NCH];
  logic [ACC_W-1:0] inc_q   [NCH];
  logic [ACC_W-1:0] nxt_acc [NCH];
  logic [ACC_W:0]   half_sum[NCH];
  logic [NCH-1:0]   carry_a;
  logic [NCH-1:0]   carry_b;
  logic [NCH-1:0]   apply_v;

  // The pending slot is full exactly when o_inc_rdy is low.
  logic [CH_W-1:0]  pend_ch;
  logic [ACC_W-1:0] pend_val;

  always_comb begin
    carry_a  = '0;
    carry_b  = '0;
    apply_v  = '0;
    nxt_acc  = '{default: '0};
    half_sum = '{default: '0};
    for (int i = 0; i < NCH; i++) begin
      {carry_a[i], nxt_acc[i]} = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      // Shadow accumulator offset by half a turn gives the 180-degree enable.
      half_sum[i] = {1'b0, acc_q[i] ^ HALF} + {1'b0, inc_q[i]};
      carry_b[i]  = half_sum[i][ACC_W];
      // Swap the increment only at a period boundary so no period is cut short;
      // a stopped channel has no boundary, so it takes the value right away.
      apply_v[i] = !o_inc_rdy && (pend_ch == CH_W'(i)) &&
                   (carry_a[i] || (inc_q[i] == '0));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= PHASE0[i*ACC_W +: ACC_W];
        inc_q[i] <= INC[i*ACC_W +: ACC_W];
      end
      o_cen     <= '0;
      o_cenb    <= '0;
      o_clk     <= '0;
      o_inc_rdy <= 1'b1;
      pend_ch   <= '0;
      pend_val  <= '0;
    end else begin
      if (i_run) begin
        o_cen  <= carry_a;
        o_cenb <= carry_b;
        for (int i = 0; i < NCH; i++) begin
          acc_q[i] <= nxt_acc[i];
          // Rising edge on cen has priority when both carries fire.
          if (carry_a[i]) begin
            o_clk[i] <= 1'b1;
          end else if (carry_b[i]) begin
            o_clk[i] <= 1'b0;
          end
          if (apply_v[i]) begin
            inc_q[i] <= pend_val;
          end
        end
        if (|apply_v) begin
          o_inc_rdy <= 1'b1;
        end
      end else begin
        o_cen  <= '0;
        o_cenb <= '0;
      end
      // Accept only with an empty slot; apply_v is all-zero then, so no conflict.
      if (i_inc_wr && o_inc_rdy && (32'(i_inc_ch) < 32'(NCH))) begin
        pend_ch   <= i_inc_ch;
        pend_val  <= i_inc_val;
        o_inc_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frac_cen_gen.sv
// tb_frac_cen_gen: directed bench for frac_cen_gen with hand-computed expectations.
// Instance dut4: 3 channels, 4-bit accumulators; instance dut16: 1 channel, 16-bit.
module tb_frac_cen_gen;

  logic       clk = 1'b0;
  logic       rst, run, wr;
  logic [1:0] ch;
  logic [3:0] val;
  logic       rdy;
  logic [2:0] cen, cenb, oclk;

  logic        rst16, run16;
  logic        wr16 = 1'b0;
  logic        ch16 = 1'b0;
  logic [15:0] val16 = 16'd0;
  logic        rdy16;
  logic [0:0]  cen16, cenb16, oclk16;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  frac_cen_gen #(
    .NCH(3), .ACC_W(4),
    .INC({4'd12, 4'd0, 4'd4}),
    .PHASE0({4'd0, 4'd0, 4'd4})
  ) dut4 (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .i_inc_wr(wr), .i_inc_ch(ch), .i_inc_val(val),
    .o_inc_rdy(rdy), .o_cen(cen), .o_cenb(cenb), .o_clk(oclk)
  );

  frac_cen_gen #(
    .NCH(1), .ACC_W(16),
    .INC(16'd4891),
    .PHASE0(16'd63583)
  ) dut16 (
    .i_clk(clk), .i_rst(rst16), .i_run(run16),
    .i_inc_wr(wr16), .i_inc_ch(ch16), .i_inc_val(val16),
    .o_inc_rdy(rdy16), .o_cen(cen16), .o_cenb(cenb16), .o_clk(oclk16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_cen  = 8'b0100_0100;  // bit k-1: after edge k
  logic [7:0] exp_cenb = 8'b0001_0001;
  logic [7:0] exp_clk  = 8'b1100_1100;

  initial begin
    int cnt, last, bad, both;
    rst = 1'b1; run = 1'b1; wr = 1'b0; ch = 2'd0; val = 4'd0;
    rst16 = 1'b1; run16 = 1'b0;

    // Reset state
    step();
    chk("rst cen", 32'(cen), 0);
    chk("rst cenb", 32'(cenb), 0);
    chk("rst clk", 32'(oclk), 0);
    chk("rst rdy", 32'(rdy), 1);
    chk("rst acc0", 32'(dut4.acc_q[0]), 4);
    chk("rst inc1", 32'(dut4.inc_q[1]), 0);
    rst = 1'b0;

    // inc=4 from phase 4: acc 8,12,0,...; cen after 3,7; cenb after 1,5
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("ch0 cen", 32'(cen[0]), 32'(exp_cen[k-1]));
      chk("ch0 cenb", 32'(cenb[0]), 32'(exp_cenb[k-1]));
      chk("ch0 clk", 32'(oclk[0]), 32'(exp_clk[k-1]));
      chk("ch0 acc", 32'(dut4.acc_q[0]), 32'((4 + 4*k) % 16));
      chk("ch1 idle", 32'(cen[1] | cenb[1]), 0);
      if (k == 2) begin
        // inc=12 > half: both carries fire, cen wins for o_clk
        chk("ch2 cen both", 32'(cen[2]), 1);
        chk("ch2 cenb both", 32'(cenb[2]), 1);
        chk("ch2 clk both", 32'(oclk[2]), 1);
      end
    end

    // Mid-period write inc=2 on ch0, then a dropped second write
    wr = 1'b1; ch = 2'd0; val = 4'd2;
    step();                                   // edge 9
    chk("wr rdy low", 32'(rdy), 0);
    val = 4'd1;
    step();                                   // edge 10
    chk("wr2 rdy low", 32'(rdy), 0);
    wr = 1'b0;
    step();                                   // edge 11
    chk("apply cen", 32'(cen[0]), 1);
    chk("apply rdy", 32'(rdy), 1);
    for (int k = 12; k <= 19; k++) begin
      step();
      chk("inc2 cen", 32'(cen[0]), 32'(k == 19));
      chk("inc2 cenb", 32'(cenb[0]), 32'(k == 15));
    end

    // Drop run for 5 edges
    run = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("stall en", 32'(cen | cenb), 0);
      chk("stall acc0", 32'(dut4.acc_q[0]), 0);
      chk("stall clk0", 32'(oclk[0]), 1);
    end
    run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("resume cen", 32'(cen[0]), 32'(k == 8));
    end

    // Reset mid-handshake with o_clk high
    chk("pre clk0", 32'(oclk[0]), 1);
    wr = 1'b1; ch = 2'd0; val = 4'd1;
    step();
    chk("pend rdy", 32'(rdy), 0);
    chk("pend clk0", 32'(oclk[0]), 1);
    wr = 1'b0; rst = 1'b1;
    step();
    chk("mid rst cen", 32'(cen), 0);
    chk("mid rst cenb", 32'(cenb), 0);
    chk("mid rst clk", 32'(oclk), 0);
    chk("mid rst rdy", 32'(rdy), 1);
    chk("mid rst acc0", 32'(dut4.acc_q[0]), 4);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("post rst cen", 32'(cen[0]), 32'(k == 3 || k == 7 || k == 11 || k == 15));
    end
    chk("post rst inc0", 32'(dut4.inc_q[0]), 4);

    // Write to a stopped channel applies one edge after acceptance
    wr = 1'b1; ch = 2'd1; val = 4'd4;
    step();
    chk("z acc rdy", 32'(rdy), 0);
    chk("z acc inc1", 32'(dut4.inc_q[1]), 0);
    wr = 1'b0;
    step();
    chk("z app rdy", 32'(rdy), 1);
    chk("z app inc1", 32'(dut4.inc_q[1]), 4);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("z cen1", 32'(cen[1]), 32'(k == 4));
    end

    // Out-of-range channel is ignored
    wr = 1'b1; ch = 2'd3; val = 4'd1;
    step();
    chk("bad ch rdy", 32'(rdy), 1);
    wr = 1'b0;
    step();
    chk("bad ch rdy2", 32'(rdy), 1);
    chk("bad ch inc0", 32'(dut4.inc_q[0]), 4);

    // 16-bit channel: full 2^16-cycle turn
    chk("r16 cen", 32'(cen16), 0);
    chk("r16 clk", 32'(oclk16), 0);
    chk("r16 rdy", 32'(rdy16), 1);
    chk("r16 acc", 32'(dut16.acc_q[0]), 63583);
    rst16 = 1'b0; run16 = 1'b1;
    step();
    chk("c16 first", 32'(cen16), 1);
    cnt = 1; last = 1; bad = 0; both = 0;
    for (int k = 2; k <= 65536; k++) begin
      step();
      if (cen16[0] && cenb16[0]) both++;
      if (cen16[0]) begin
        if ((k - last) < 13 || (k - last) > 14) bad++;
        cnt++;
        last = k;
      end
    end
    chk("c16 count", 32'(cnt), 4891);
    chk("c16 gaps", 32'(bad), 0);
    chk("c16 overlap", 32'(both), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frac_cen_gen.md
# frac_cen_gen

Parametrised multi-channel fractional clock-enable generator for the core clock tree. Each channel runs a phase accumulator on the single master clock. Every period it produces a one-cycle enable and a half-period-shifted complementary enable, and it derives a 50%-duty registered clock from the pair. Per-channel increments load safely at run time without a glitch. The block replaces fixed per-rate dividers, so one instance can serve all CPU, video and sound enables.

## Interface
- NCH, 4: number of channels (1..16)
- ACC_W, 16: accumulator width in bits (4..24)
- INC, {NCH{ACC_W'd4891}}: packed reset increments; channel i is in bits [i*ACC_W +: ACC_W]
- PHASE0, {NCH{ACC_W'd0}}: packed reset accumulator values, using the same packing as INC

Ports:
- i_clk  in  1  master clock; all logic is on posedge
- i_rst  in  1  synchronous reset, active-high
- i_run  in  1  global run; while low, accumulators hold and the enables are forced to 0
- i_inc_wr  in  1  increment write strobe
- i_inc_ch  in  max(1,$clog2(NCH))  target channel of the write
- i_inc_val  in  ACC_W  new increment value
- o_inc_rdy  out  1  write can be accepted
- o_cen  out  NCH  per-channel enable, one cycle wide
- o_cenb  out  NCH  per-channel enable shifted by 180 degrees
- o_clk  out  NCH  per-channel registered square clock

## Operation
- Per channel i, each cycle with i_run=1 and i_rst=0:
  - sum = {1'b0,acc} + inc, ACC_W+1 bits wide
  - acc <= sum[ACC_W-1:0], so the accumulator wraps modulo 2^ACC_W
  - o_cen[i] <= sum[ACC_W]
- Half-period enable: o_cenb[i] <= carry of ({1'b0, acc ^ 2^(ACC_W-1)} + inc). This is the carry of a shadow accumulator offset by half a turn.
- o_clk[i]:
  - set to 1 on a cycle where the o_cen carry fires
  - else cleared to 0 where the o_cenb carry fires
  - else held
  - If both fire (inc > 2^(ACC_W-1)), cen wins.
- Average enable rate = f_clk * inc / 2^ACC_W. An increment of 0 stops the channel: no enables, and o_clk holds.
- i_run=0:
  - acc and o_clk hold
  - o_cen = o_cenb = 0 from the next edge
  - When i_run returns, accumulation resumes from the held acc.
- Increment write handshake:
  - A write is accepted when i_inc_wr=1 and o_inc_rdy=1 on the same edge.
  - Accepted values are stored in a single pending slot (value plus channel); o_inc_rdy <= 0 while the slot is full.
  - The pending value becomes the channel's inc on the edge where that channel's cen carry fires. The sum on that same edge still uses the old inc, and the next sum uses the new one.
  - If the target channel's current inc is 0, the value applies on the edge after acceptance.
  - The pending slot is only applied while i_run=1.
  - o_inc_rdy returns to 1 on the edge of application.
  - A write with i_inc_ch >= NCH is ignored and o_inc_rdy stays 1.
  - A write while o_inc_rdy=0 is dropped.
- Reset, applied on any edge where i_rst=1, including mid-operation and mid-handshake:
  - acc <= PHASE0[i], inc <= INC[i]
  - o_cen = o_cenb = o_clk = 0
  - pending slot cleared, o_inc_rdy = 1
  - i_rst has priority over i_run and i_inc_wr.

## Timing
- All outputs are registered. An enable is visible in the cycle after the edge whose sum carried, and it lasts exactly 1 cycle.
- The first possible enable is on the first edge after i_rst falls, with i_run=1.
- For inc <= 2^(ACC_W-1), the gap between consecutive o_cen pulses is floor or ceil of 2^ACC_W/inc cycles. o_cen and o_cenb never assert in the same cycle.
- For inc = 2^ACC_W/2^k, o_cenb is exactly half a period after o_cen.
- Write-to-effect latency is 1 cycle to enter the pending slot, then up to one channel period.
- No combinational path from any input to any output.

## Test plan
- ACC_W=4, INC=4, PHASE0=4, i_run=1 after reset -> acc goes 8, 12, 0. o_cen is high after edge 3 and then every 4 cycles. o_cenb is high after edge 1 and then every 4 cycles. o_clk is a 50% square of period 4.
- ACC_W=16, INC=4891, PHASE0=63583 -> o_cen is high after edge 1. Over 65536 cycles, exactly 4891 o_cen pulses, with every gap 13 or 14 cycles.
- Run a channel at inc=4 (ACC_W=4), then write inc=2 mid-period -> o_inc_rdy is low until the next o_cen. The period is 4 up to and including that pulse, and 8 afterwards. A second write while o_inc_rdy=0 has no effect.
- Drop i_run for 5 cycles -> no enables, and acc and o_clk are frozen. On resume, the next o_cen lands 5 cycles later than it would have.
- Pulse i_rst with a write pending and o_clk=1 -> the next cycle shows all outputs 0, o_inc_rdy=1 and acc=PHASE0. The pending value is never applied.
- Write to a channel with inc=0, and separately write with i_inc_ch=NCH -> the first applies 1 cycle after acceptance. The second is ignored with o_inc_rdy staying 1.
